// File: rtl/scgra_axil_ctrl_slave_if.sv
// AXI4-Lite bundle between the host master and the SCGRA control slave.
// Ports: AW/W/B/AR/R channels; master modport drives requests, slave responds.
interface scgra_axil_ctrl_slave_if #(
    parameter int C_DATA_WIDTH = 32,
    parameter int C_ADDR_WIDTH = 5
) ();

    logic [C_ADDR_WIDTH-1:0]   S_AXI_AWADDR;
    logic [2:0]                S_AXI_AWPROT;
    logic                      S_AXI_AWVALID;
    logic                      S_AXI_AWREADY;

    logic [C_DATA_WIDTH-1:0]   S_AXI_WDATA;
    logic [C_DATA_WIDTH/8-1:0] S_AXI_WSTRB;
    logic                      S_AXI_WVALID;
    logic                      S_AXI_WREADY;

    logic [1:0]                S_AXI_BRESP;
    logic                      S_AXI_BVALID;
    logic                      S_AXI_BREADY;

    logic [C_ADDR_WIDTH-1:0]   S_AXI_ARADDR;
    logic [2:0]                S_AXI_ARPROT;
    logic                      S_AXI_ARVALID;
    logic                      S_AXI_ARREADY;

    logic [C_DATA_WIDTH-1:0]   S_AXI_RDATA;
    logic [1:0]                S_AXI_RRESP;
    logic                      S_AXI_RVALID;
    logic                      S_AXI_RREADY;

    modport master (
        output S_AXI_AWADDR, S_AXI_AWPROT, S_AXI_AWVALID,
        input  S_AXI_AWREADY,
        output S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WVALID,
        input  S_AXI_WREADY,
        input  S_AXI_BRESP, S_AXI_BVALID,
        output S_AXI_BREADY,
        output S_AXI_ARADDR, S_AXI_ARPROT, S_AXI_ARVALID,
        input  S_AXI_ARREADY,
        input  S_AXI_RDATA, S_AXI_RRESP, S_AXI_RVALID,
        output S_AXI_RREADY
    );

    modport slave (
        input  S_AXI_AWADDR, S_AXI_AWPROT, S_AXI_AWVALID,
        output S_AXI_AWREADY,
        input  S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WVALID,
        output S_AXI_WREADY,
        output S_AXI_BRESP, S_AXI_BVALID,
        input  S_AXI_BREADY,
        input  S_AXI_ARADDR, S_AXI_ARPROT, S_AXI_ARVALID,
        output S_AXI_ARREADY,
        output S_AXI_RDATA, S_AXI_RRESP, S_AXI_RVALID,
        input  S_AXI_RREADY
    );

endinterface

// File: rtl/scgra_axil_ctrl_slave.sv
// AXI4-Lite control/status register bank for the SCGRA accelerator core.
// Ports: ACLK, ARESETN (async low), s_axi (slave modport), cfg0..cfg3 config
// words, acc_start one-cycle start pulse, acc_done completion in, acc_irq level.
module scgra_axil_ctrl_slave #(
    parameter int C_DATA_WIDTH = 32,
    parameter int C_ADDR_WIDTH = 5
) (
    input  logic                    ACLK,
    input  logic                    ARESETN,
    scgra_axil_ctrl_slave_if.slave  s_axi,
    output logic [C_DATA_WIDTH-1:0] cfg0,
    output logic [C_DATA_WIDTH-1:0] cfg1,
    output logic [C_DATA_WIDTH-1:0] cfg2,
    output logic [C_DATA_WIDTH-1:0] cfg3,
    output logic                    acc_start,
    input  logic                    acc_done,
    output logic                    acc_irq
);

    typedef enum logic [1:0] {
        W_IDLE   = 2'd0,
        W_ACCEPT = 2'd1,
        W_RESP   = 2'd2
    } wstate_t;

    typedef enum logic [1:0] {
        R_IDLE   = 2'd0,
        R_ACCEPT = 2'd1,
        R_DATA   = 2'd2
    } rstate_t;

    localparam logic [2:0] IDX_CTRL   = 3'd4;
    localparam logic [2:0] IDX_STATUS = 3'd5;

    // ---------------- state and registers ----------------
    wstate_t                 r_wstate;
    wstate_t                 w_wstate_nxt;
    rstate_t                 r_rstate;
    rstate_t                 r_rstate_nxt;

    logic [C_DATA_WIDTH-1:0] r_cfg [4];
    logic                    r_irq_en;
    logic                    r_busy;
    logic                    r_done;
    logic                    r_start;
    logic [C_DATA_WIDTH-1:0] r_rdata;

    // ---------------- bus-facing wires ----------------
    logic                    w_awready;
    logic                    w_wready;
    logic                    w_bvalid;
    logic                    w_arready;
    logic                    w_rvalid;

    logic [2:0]              w_awidx;
    logic [2:0]              w_aridx;
    logic                    w_wr_en;
    logic                    w_rd_en;
    logic                    w_ctrl_wr;
    logic                    w_start_fire;
    logic                    w_done_w1c;
    logic [C_DATA_WIDTH-1:0] w_rdata_mux;
    logic                    w_unused;

    assign w_awidx = s_axi.S_AXI_AWADDR[4:2];
    assign w_aridx = s_axi.S_AXI_ARADDR[4:2];

    // Address/data are sampled on the ACCEPT edge, where the handshake lands.
    assign w_wr_en = (r_wstate == W_ACCEPT);
    assign w_rd_en = (r_rstate == R_ACCEPT);

    assign w_ctrl_wr = w_wr_en
                     && (w_awidx == IDX_CTRL)
                     && s_axi.S_AXI_WSTRB[0];

    // A START while the core is still running is dropped silently.
    assign w_start_fire = w_ctrl_wr
                        && s_axi.S_AXI_WDATA[0]
                        && !r_busy;

    assign w_done_w1c = w_wr_en
                      && (w_awidx == IDX_STATUS)
                      && s_axi.S_AXI_WSTRB[0]
                      && s_axi.S_AXI_WDATA[1];

    assign w_unused = ^{s_axi.S_AXI_AWPROT, s_axi.S_AXI_ARPROT,
                        s_axi.S_AXI_AWADDR[1:0], s_axi.S_AXI_ARADDR[1:0]};

    // ---------------- write FSM ----------------
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            r_wstate <= W_IDLE;
        end else begin
            r_wstate <= w_wstate_nxt;
        end
    end

    always_comb begin
        w_wstate_nxt = r_wstate;
        unique case (r_wstate)
            W_IDLE: begin
                // AW and W are only taken together.
                if (s_axi.S_AXI_AWVALID && s_axi.S_AXI_WVALID) begin
                    w_wstate_nxt = W_ACCEPT;
                end
            end
            W_ACCEPT: begin
                w_wstate_nxt = W_RESP;
            end
            W_RESP: begin
                if (s_axi.S_AXI_BREADY) begin
                    w_wstate_nxt = W_IDLE;
                end
            end
            default: begin
                w_wstate_nxt = W_IDLE;
            end
        endcase
    end

    always_comb begin
        w_awready = 1'b0;
        w_wready  = 1'b0;
        w_bvalid  = 1'b0;
        unique case (r_wstate)
            W_IDLE: begin
            end
            W_ACCEPT: begin
                w_awready = 1'b1;
                w_wready  = 1'b1;
            end
            W_RESP: begin
                w_bvalid = 1'b1;
            end
            default: begin
            end
        endcase
    end

    // ---------------- read FSM ----------------
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            r_rstate <= R_IDLE;
        end else begin
            r_rstate <= r_rstate_nxt;
        end
    end

    always_comb begin
        r_rstate_nxt = r_rstate;
        unique case (r_rstate)
            R_IDLE: begin
                if (s_axi.S_AXI_ARVALID) begin
                    r_rstate_nxt = R_ACCEPT;
                end
            end
            R_ACCEPT: begin
                r_rstate_nxt = R_DATA;
            end
            R_DATA: begin
                if (s_axi.S_AXI_RREADY) begin
                    r_rstate_nxt = R_IDLE;
                end
            end
            default: begin
                r_rstate_nxt = R_IDLE;
            end
        endcase
    end

    always_comb begin
        w_arready = 1'b0;
        w_rvalid  = 1'b0;
        unique case (r_rstate)
            R_IDLE: begin
            end
            R_ACCEPT: begin
                w_arready = 1'b1;
            end
            R_DATA: begin
                w_rvalid = 1'b1;
            end
            default: begin
            end
        endcase
    end

    // ---------------- byte-lane merge ----------------
    function automatic logic [C_DATA_WIDTH-1:0] f_merge(
        input logic [C_DATA_WIDTH-1:0]   old_v,
        input logic [C_DATA_WIDTH-1:0]   new_v,
        input logic [C_DATA_WIDTH/8-1:0] strb
    );
        logic [C_DATA_WIDTH-1:0] res;
        res = old_v;
        for (int b = 0; b < C_DATA_WIDTH / 8; b++) begin
            if (strb[b]) begin
                res[8*b +: 8] = new_v[8*b +: 8];
            end
        end
        return res;
    endfunction

    // ---------------- config registers ----------------
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            for (int i = 0; i < 4; i++) begin
                r_cfg[i] <= '0;
            end
        end else if (w_wr_en && !w_awidx[2]) begin
            r_cfg[w_awidx[1:0]] <= f_merge(r_cfg[w_awidx[1:0]],
                                           s_axi.S_AXI_WDATA,
                                           s_axi.S_AXI_WSTRB);
        end
    end

    // ---------------- control / status ----------------
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            r_irq_en <= 1'b0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_start  <= 1'b0;
        end else begin
            r_start <= w_start_fire;

            if (w_ctrl_wr) begin
                r_irq_en <= s_axi.S_AXI_WDATA[1];
            end

            // A fresh start owns BUSY even if a stray done lands alongside.
            if (w_start_fire) begin
                r_busy <= 1'b1;
            end else if (acc_done) begin
                r_busy <= 1'b0;
            end

            // Completion beats a simultaneous W1C so no done is ever lost.
            if (acc_done) begin
                r_done <= 1'b1;
            end else if (w_done_w1c) begin
                r_done <= 1'b0;
            end
        end
    end

    // ---------------- read data ----------------
    always_comb begin
        w_rdata_mux = '0;
        unique case (w_aridx)
            3'd0:       w_rdata_mux = r_cfg[0];
            3'd1:       w_rdata_mux = r_cfg[1];
            3'd2:       w_rdata_mux = r_cfg[2];
            3'd3:       w_rdata_mux = r_cfg[3];
            IDX_CTRL:   w_rdata_mux[1] = r_irq_en;
            IDX_STATUS: w_rdata_mux[1:0] = {r_done, r_busy};
            default:    w_rdata_mux = '0;
        endcase
    end

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            r_rdata <= '0;
        end else if (w_rd_en) begin
            r_rdata <= w_rdata_mux;
        end
    end

    // ---------------- outputs ----------------
    assign s_axi.S_AXI_AWREADY = w_awready;
    assign s_axi.S_AXI_WREADY  = w_wready;
    assign s_axi.S_AXI_BVALID  = w_bvalid;
    assign s_axi.S_AXI_BRESP   = 2'b00;
    assign s_axi.S_AXI_ARREADY = w_arready;
    assign s_axi.S_AXI_RVALID  = w_rvalid;
    assign s_axi.S_AXI_RRESP   = 2'b00;
    assign s_axi.S_AXI_RDATA   = r_rdata;

    assign cfg0      = r_cfg[0];
    assign cfg1      = r_cfg[1];
    assign cfg2      = r_cfg[2];
    assign cfg3      = r_cfg[3];
    assign acc_start = r_start;
    assign acc_irq   = r_done & r_irq_en;

endmodule

// File: tb/tb_scgra_axil_ctrl_slave.sv
// Directed bench for the SCGRA AXI4-Lite control slave.
// Drives and samples on the falling clock edge; checks via immediate asserts.
module tb_scgra_axil_ctrl_slave;

    logic        clk;
    logic        rst_n;
    logic [31:0] cfg0, cfg1, cfg2, cfg3;
    logic        acc_start;
    logic        acc_done;
    logic        acc_irq;

    int n_chk;
    int n_err;
    logic g_start;
    logic g_start_next;
    logic [31:0] rdv;

    scgra_axil_ctrl_slave_if #(.C_DATA_WIDTH(32), .C_ADDR_WIDTH(5)) bus ();

    scgra_axil_ctrl_slave #(.C_DATA_WIDTH(32), .C_ADDR_WIDTH(5)) dut (
        .ACLK      (clk),
        .ARESETN   (rst_n),
        .s_axi     (bus.slave),
        .cfg0      (cfg0),
        .cfg1      (cfg1),
        .cfg2      (cfg2),
        .cfg3      (cfg3),
        .acc_start (acc_start),
        .acc_done  (acc_done),
        .acc_irq   (acc_irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic wr(input logic [4:0] a, input logic [31:0] d,
                      input logic [3:0] s);
        int n;
        bus.S_AXI_AWADDR  = a;
        bus.S_AXI_WDATA   = d;
        bus.S_AXI_WSTRB   = s;
        bus.S_AXI_AWVALID = 1'b1;
        bus.S_AXI_WVALID  = 1'b1;
        bus.S_AXI_BREADY  = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!bus.S_AXI_AWREADY && n < 10);
        chk("aw_latency", n, 1);
        chk("wready", {31'b0, bus.S_AXI_WREADY}, 1);
        @(negedge clk);
        bus.S_AXI_AWVALID = 1'b0;
        bus.S_AXI_WVALID  = 1'b0;
        chk("bvalid", {31'b0, bus.S_AXI_BVALID}, 1);
        chk("bresp", {30'b0, bus.S_AXI_BRESP}, 0);
        g_start = acc_start;
        @(negedge clk);
        g_start_next = acc_start;
        chk("b_done", {31'b0, bus.S_AXI_BVALID}, 0);
    endtask

    task automatic rd(input logic [4:0] a, output logic [31:0] d);
        int n;
        bus.S_AXI_ARADDR  = a;
        bus.S_AXI_ARVALID = 1'b1;
        bus.S_AXI_RREADY  = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!bus.S_AXI_ARREADY && n < 10);
        chk("ar_latency", n, 1);
        @(negedge clk);
        bus.S_AXI_ARVALID = 1'b0;
        chk("rvalid", {31'b0, bus.S_AXI_RVALID}, 1);
        chk("rresp", {30'b0, bus.S_AXI_RRESP}, 0);
        d = bus.S_AXI_RDATA;
        @(negedge clk);
        chk("r_done", {31'b0, bus.S_AXI_RVALID}, 0);
    endtask

    task automatic rd_chk(input string tag, input logic [4:0] a,
                          input logic [31:0] exp);
        logic [31:0] d;
        rd(a, d);
        chk(tag, d, exp);
    endtask

    initial begin
        n_chk = 0;
        n_err = 0;
        g_start = 1'b0;
        g_start_next = 1'b0;
        rst_n = 1'b0;
        acc_done = 1'b0;
        bus.S_AXI_AWADDR  = '0;
        bus.S_AXI_AWPROT  = '0;
        bus.S_AXI_AWVALID = 1'b0;
        bus.S_AXI_WDATA   = '0;
        bus.S_AXI_WSTRB   = '0;
        bus.S_AXI_WVALID  = 1'b0;
        bus.S_AXI_BREADY  = 1'b0;
        bus.S_AXI_ARADDR  = '0;
        bus.S_AXI_ARPROT  = '0;
        bus.S_AXI_ARVALID = 1'b0;
        bus.S_AXI_RREADY  = 1'b0;

        // reset state
        repeat (3) @(negedge clk);
        chk("rst_awready", {31'b0, bus.S_AXI_AWREADY}, 0);
        chk("rst_wready", {31'b0, bus.S_AXI_WREADY}, 0);
        chk("rst_bvalid", {31'b0, bus.S_AXI_BVALID}, 0);
        chk("rst_arready", {31'b0, bus.S_AXI_ARREADY}, 0);
        chk("rst_rvalid", {31'b0, bus.S_AXI_RVALID}, 0);
        chk("rst_rdata", bus.S_AXI_RDATA, 0);
        chk("rst_cfg0", cfg0, 0);
        chk("rst_cfg3", cfg3, 0);
        chk("rst_start", {31'b0, acc_start}, 0);
        chk("rst_irq", {31'b0, acc_irq}, 0);
        rst_n = 1'b1;
        @(negedge clk);

        // config words
        wr(5'h00, 32'h0101FFFF, 4'hF);
        chk("cfg0_out", cfg0, 32'h0101FFFF);
        wr(5'h04, 32'hABCD0001, 4'hF);
        chk("cfg1_out", cfg1, 32'hABCD0001);
        wr(5'h08, 32'hDEAD0011, 4'hF);
        chk("cfg2_out", cfg2, 32'hDEAD0011);
        wr(5'h0C, 32'hBEEF0011, 4'hF);
        chk("cfg3_out", cfg3, 32'hBEEF0011);
        rd_chk("cfg0_rd", 5'h00, 32'h0101FFFF);
        rd_chk("cfg1_rd", 5'h04, 32'hABCD0001);
        rd_chk("cfg2_rd", 5'h08, 32'hDEAD0011);
        rd_chk("cfg3_rd", 5'h0C, 32'hBEEF0011);
        rd_chk("ctrl_rst_rd", 5'h10, 32'h0);
        rd_chk("rsvd_rd", 5'h18, 32'h0);

        // byte strobes
        wr(5'h04, 32'h12345678, 4'b0101);
        rd_chk("strb_rd", 5'h04, 32'hAB340078);
        chk("strb_cfg1", cfg1, 32'hAB340078);

        // reserved write ignored
        wr(5'h1C, 32'hFFFFFFFF, 4'hF);
        rd_chk("rsvd_wr_rd", 5'h1C, 32'h0);

        // start
        wr(5'h10, 32'h3, 4'hF);
        chk("start_pulse", {31'b0, g_start}, 1);
        chk("start_one_cyc", {31'b0, g_start_next}, 0);
        rd_chk("status_busy", 5'h14, 32'h1);
        rd_chk("ctrl_rd", 5'h10, 32'h2);
        chk("irq_busy", {31'b0, acc_irq}, 0);
        wr(5'h10, 32'h3, 4'hF);
        chk("start_blocked", {31'b0, g_start}, 0);
        chk("start_blocked2", {31'b0, g_start_next}, 0);

        // done
        acc_done = 1'b1;
        @(negedge clk);
        acc_done = 1'b0;
        chk("irq_done", {31'b0, acc_irq}, 1);
        rd_chk("status_done", 5'h14, 32'h2);
        wr(5'h14, 32'h2, 4'hF);
        chk("irq_w1c", {31'b0, acc_irq}, 0);
        rd_chk("status_w1c", 5'h14, 32'h0);

        // W1C colliding with done: set wins
        bus.S_AXI_AWADDR  = 5'h14;
        bus.S_AXI_WDATA   = 32'h2;
        bus.S_AXI_WSTRB   = 4'hF;
        bus.S_AXI_AWVALID = 1'b1;
        bus.S_AXI_WVALID  = 1'b1;
        bus.S_AXI_BREADY  = 1'b1;
        @(negedge clk);
        chk("coll_accept", {31'b0, bus.S_AXI_AWREADY}, 1);
        acc_done = 1'b1;
        @(negedge clk);
        acc_done = 1'b0;
        bus.S_AXI_AWVALID = 1'b0;
        bus.S_AXI_WVALID  = 1'b0;
        chk("coll_bvalid", {31'b0, bus.S_AXI_BVALID}, 1);
        @(negedge clk);
        rd_chk("coll_status", 5'h14, 32'h2);
        chk("coll_irq", {31'b0, acc_irq}, 1);

        // write response back-pressure
        bus.S_AXI_AWADDR  = 5'h08;
        bus.S_AXI_WDATA   = 32'h5A5A5A5A;
        bus.S_AXI_WSTRB   = 4'hF;
        bus.S_AXI_AWVALID = 1'b1;
        bus.S_AXI_WVALID  = 1'b1;
        bus.S_AXI_BREADY  = 1'b0;
        @(negedge clk);
        @(negedge clk);
        bus.S_AXI_AWVALID = 1'b0;
        bus.S_AXI_WVALID  = 1'b0;
        for (int i = 0; i < 5; i++) begin
            chk("bp_bvalid", {31'b0, bus.S_AXI_BVALID}, 1);
            chk("bp_cfg2", cfg2, 32'h5A5A5A5A);
            @(negedge clk);
        end
        bus.S_AXI_BREADY = 1'b1;
        @(negedge clk);
        chk("bp_bvalid_drop", {31'b0, bus.S_AXI_BVALID}, 0);

        // read data back-pressure
        bus.S_AXI_ARADDR  = 5'h08;
        bus.S_AXI_ARVALID = 1'b1;
        bus.S_AXI_RREADY  = 1'b0;
        @(negedge clk);
        chk("bp_arready", {31'b0, bus.S_AXI_ARREADY}, 1);
        @(negedge clk);
        bus.S_AXI_ARVALID = 1'b0;
        for (int i = 0; i < 5; i++) begin
            chk("bp_rvalid", {31'b0, bus.S_AXI_RVALID}, 1);
            chk("bp_rdata", bus.S_AXI_RDATA, 32'h5A5A5A5A);
            @(negedge clk);
        end
        chk("bp_rvalid_last", {31'b0, bus.S_AXI_RVALID}, 1);
        bus.S_AXI_RREADY = 1'b1;
        @(negedge clk);
        chk("bp_rvalid_drop", {31'b0, bus.S_AXI_RVALID}, 0);

        // AW without W is not accepted
        bus.S_AXI_AWADDR  = 5'h0C;
        bus.S_AXI_WDATA   = 32'h11112222;
        bus.S_AXI_WSTRB   = 4'hF;
        bus.S_AXI_AWVALID = 1'b1;
        bus.S_AXI_WVALID  = 1'b0;
        bus.S_AXI_BREADY  = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("aw_only_awready", {31'b0, bus.S_AXI_AWREADY}, 0);
            chk("aw_only_wready", {31'b0, bus.S_AXI_WREADY}, 0);
        end
        bus.S_AXI_WVALID = 1'b1;
        @(negedge clk);
        chk("aw_w_awready", {31'b0, bus.S_AXI_AWREADY}, 1);
        @(negedge clk);
        bus.S_AXI_AWVALID = 1'b0;
        bus.S_AXI_WVALID  = 1'b0;
        chk("aw_w_bvalid", {31'b0, bus.S_AXI_BVALID}, 1);
        chk("aw_w_cfg3", cfg3, 32'h11112222);
        @(negedge clk);

        // reset during RESP
        bus.S_AXI_AWADDR  = 5'h00;
        bus.S_AXI_WDATA   = 32'hCAFEF00D;
        bus.S_AXI_AWVALID = 1'b1;
        bus.S_AXI_WVALID  = 1'b1;
        bus.S_AXI_BREADY  = 1'b0;
        @(negedge clk);
        @(negedge clk);
        bus.S_AXI_AWVALID = 1'b0;
        bus.S_AXI_WVALID  = 1'b0;
        chk("pre_rst_bvalid", {31'b0, bus.S_AXI_BVALID}, 1);
        chk("pre_rst_cfg0", cfg0, 32'hCAFEF00D);
        chk("pre_rst_irq", {31'b0, acc_irq}, 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_bvalid", {31'b0, bus.S_AXI_BVALID}, 0);
        chk("arst_cfg0", cfg0, 0);
        chk("arst_cfg2", cfg2, 0);
        chk("arst_rdata", bus.S_AXI_RDATA, 0);
        chk("arst_irq", {31'b0, acc_irq}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        bus.S_AXI_BREADY = 1'b1;
        @(negedge clk);
        chk("post_rst_bvalid", {31'b0, bus.S_AXI_BVALID}, 0);
        rd_chk("post_cfg0", 5'h00, 32'h0);
        rd_chk("post_cfg1", 5'h04, 32'h0);
        rd_chk("post_cfg2", 5'h08, 32'h0);
        rd_chk("post_cfg3", 5'h0C, 32'h0);
        rd_chk("post_ctrl", 5'h10, 32'h0);
        rd_chk("post_status", 5'h14, 32'h0);

        rd(5'h14, rdv);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
